pipe_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable and bubble-insert (flush) controls of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) from hazard, redirect, memory-busy and halt inputs. Owns the halt-drain state machine, which retires in-flight instructions before freezing the core.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding plus register-width and drain-length defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_e;

    localparam int REG_W        = 3;
    localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// pipe_ctrl_hazard_detect: combinational load-use hazard compare.
// Ports: ID source specifiers/use flags, EX load flag and destination -> lu_o.
module pipe_ctrl_hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    output logic             lu_o
);

    logic rs_hit;
    logic rt_hit;

    // No register is exempt: a load to r0 still stalls a reader of r0.
    assign rs_hit = ifid_rs_used & (ifid_rs == idex_rd);
    assign rt_hit = ifid_rt_used & (ifid_rt == idex_rd);
    assign lu_o   = idex_mem_read & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline plus halt-drain FSM.
// Ports: hazard/redirect/memory-busy/halt inputs -> PC and latch _we/_flush, halted.
module pipe_ctrl #(
    parameter int REG_W        = pipe_ctrl_pkg::REG_W,
    parameter int DRAIN_CYCLES = pipe_ctrl_pkg::DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    input  logic             ifid_halt,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             ex_redirect,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             dmwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             dmwb_flush,
    output logic             halted
);

    import pipe_ctrl_pkg::*;

    localparam logic [1:0] CNT_INIT = 2'(DRAIN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu;

    pipe_ctrl_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_rs_used (ifid_rs_used),
        .ifid_rt_used (ifid_rt_used),
        .idex_mem_read(idex_mem_read),
        .idex_rd      (idex_rd),
        .lu_o         (lu)
    );

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        dmwb_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dmwb_flush  = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (dmem_stall) begin
                        dmwb_we    = 1'b1;
                        dmwb_flush = 1'b1;
                    end else if (ex_redirect) begin
                        // Squashes ID and EX; the hazard and halt
                        // inputs describe those dead instructions.
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        dmwb_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        dmwb_we    = 1'b1;
                    end else begin
                        pc_we      = !imem_stall;
                        ifid_we    = 1'b1;
                        ifid_flush = imem_stall;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        dmwb_we    = 1'b1;
                        if (ifid_halt) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                DRAIN: begin
                    if (dmem_stall) begin
                        dmwb_we    = 1'b1;
                        dmwb_flush = 1'b1;
                    end else begin
                        // Fetch is frozen; only bubbles follow the HALT.
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        dmwb_we    = 1'b1;
                        if (cnt_q == 2'd0) begin
                            state_d = HALTED;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
